// File: rtl/vproc_mul_iter.sv
// vproc_mul_iter: iterative 17x17 signed shift-add multiplier; optional early termination via VPROC_MUL_EARLY_TERM_EN
module vproc_mul_iter #(
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             async_rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [16:0]      op1_i,
  input  logic [16:0]      op2_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [33:0]      res_o,
  output logic [TAG_W-1:0] tag_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state;
  logic [33:0]      acc;
  logic [33:0]      mcand;
  logic [16:0]      mplier;
  logic [4:0]       cnt;
  logic             neg;
  logic [TAG_W-1:0] tag_q;
  logic [16:0]      mag1;
  logic [16:0]      mag2;
  logic [33:0]      acc_n;
  logic             last;
  // operand magnitudes, next accumulator value and end-of-iteration detect
  always_comb begin
    mag1  = op1_i[16] ? -op1_i : op1_i;
    mag2  = op2_i[16] ? -op2_i : op2_i;
    acc_n = acc + (mplier[0] ? mcand : 34'd0);
`ifdef VPROC_MUL_EARLY_TERM_EN
    last  = (mplier[16:1] == 16'd0) || (cnt == 5'd16);
`else
    last  = cnt == 5'd16;
`endif
  end
  // ready only in IDLE and never while reset is held
  assign ready_o = (state == IDLE) && !async_rst_i;
  // control FSM with datapath and registered result outputs
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      tag_q   <= '0;
      valid_o <= 1'b0;
      res_o   <= '0;
      tag_o   <= '0;
    end else if (flush_i) begin
      state   <= IDLE;
      valid_o <= 1'b0;
      res_o   <= '0;
      tag_o   <= '0;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          state  <= BUSY;
          acc    <= '0;
          cnt    <= '0;
          mcand  <= {17'd0, mag1};
          mplier <= mag2;
          neg    <= op1_i[16] ^ op2_i[16];
          tag_q  <= tag_i;
        end
        BUSY: begin
          acc    <= acc_n;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (last) begin
            state   <= DONE;
            valid_o <= 1'b1;
            res_o   <= (neg && acc_n != 34'd0) ? -acc_n : acc_n;
            tag_o   <= tag_q;
          end
        end
        DONE: if (ready_i) begin
          state   <= IDLE;
          valid_o <= 1'b0;
          res_o   <= '0;
          tag_o   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
